// File: rtl/line_sender_pkg.sv
// Shared types and constants for the line sender: FSM states, special codes
// and the qualifying-position search used for blank skipping.
package line_sender_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        TERM,
        FIN
    } state_t;

    localparam logic [3:0] BLANK_CODE   = 4'hF;
    localparam logic [7:0] QMARK        = 8'h3F;
    localparam logic [7:0] DEFAULT_TERM = 8'h0D;

    typedef struct packed {
        logic       found;
        logic [1:0] index;
    } pick_t;

    // Lowest position at or after start that is eligible to be sent; the loop
    // runs downward so the smallest qualifying index is the one left standing.
    function automatic pick_t next_qualifying(input logic [3:0][3:0] line,
                                              input logic [2:0]      start,
                                              input logic            skip_blank);
        pick_t pick;
        pick.found = 1'b0;
        pick.index = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(start)) && (!skip_blank || (line[i] != BLANK_CODE))) begin
                pick.found = 1'b1;
                pick.index = i[1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/line_sender_bcd_to_ascii.sv
// Combinational map from one display code to its ASCII character:
// digits to '0'..'9', the blank code to space, anything else to '?'.
module bcd_to_ascii
    import line_sender_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    always_comb begin
        if (digit <= 4'd9) begin
            ascii = 8'h30 | {4'h0, digit};
        end else if (digit == BLANK_CODE) begin
            ascii = 8'h20;
        end else begin
            ascii = QMARK;
        end
    end

endmodule

// File: rtl/line_sender.sv
// Streams a captured four-digit line as ASCII bytes over a valid/ready port,
// optionally skipping blanks and appending a terminator, then pulses done.
module line_sender
    import line_sender_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR  = DEFAULT_TERM,
    parameter bit         SEND_TERM  = 1'b1,
    parameter bit         SKIP_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       send,
    input  logic [3:0] Disp1,
    input  logic [3:0] Disp2,
    input  logic [3:0] Disp3,
    input  logic [3:0] Disp4,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    state_t           state;
    state_t           state_next;
    logic [1:0]       index;
    logic [1:0]       index_next;
    logic [3:0][3:0]  line;
    logic [3:0][3:0]  line_next;
    logic [3:0][3:0]  captured;
    pick_t            first_pick;
    pick_t            step_pick;
    state_t           after_last;
    logic [7:0]       digit_ascii;

    // Position 0 is Disp1, the leftmost digit and the first one sent.
    assign captured   = {Disp4, Disp3, Disp2, Disp1};
    assign first_pick = next_qualifying(captured, 3'd0, SKIP_BLANK);
    assign step_pick  = next_qualifying(line, {1'b0, index} + 3'd1, SKIP_BLANK);
    assign after_last = SEND_TERM ? TERM : FIN;

    bcd_to_ascii u_map (
        .digit (line[index]),
        .ascii (digit_ascii)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            index <= 2'd0;
            line  <= {4{BLANK_CODE}};
        end else begin
            state <= state_next;
            index <= index_next;
            line  <= line_next;
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        line_next  = line;
        case (state)
            IDLE: begin
                if (send) begin
                    line_next = captured;
                    if (first_pick.found) begin
                        state_next = SEND;
                        index_next = first_pick.index;
                    end else begin
                        state_next = after_last;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (step_pick.found) begin
                        index_next = step_pick.index;
                    end else begin
                        state_next = after_last;
                    end
                end
            end
            TERM: begin
                if (out_ready) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid = (state == SEND) || (state == TERM);
        busy      = (state != IDLE);
        done      = (state == FIN);
        case (state)
            SEND:    out_data = digit_ascii;
            TERM:    out_data = TERM_CHAR;
            default: out_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_line_sender.sv
// Scoreboard bench: three line_sender variants (default, blank skipping,
// blank skipping without terminator) share stimulus and are checked in parallel.
module tb_line_sender;

    logic       clk;
    logic       Reset;
    logic       send;
    logic [3:0] Disp1, Disp2, Disp3, Disp4;
    logic       outReady;

    logic [7:0] outData  [3];
    logic       outValid [3];
    logic       busy     [3];
    logic       done     [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int sendCyc = 0;

    logic [7:0] expQ0 [$];
    logic [7:0] expQ1 [$];
    logic [7:0] expQ2 [$];

    int         doneCnt  [3];
    int         doneCyc  [3];
    bit         stallPrev[3];
    logic [7:0] stallData[3];

    line_sender dut0 (
        .clk(clk), .Reset(Reset), .send(send),
        .Disp1(Disp1), .Disp2(Disp2), .Disp3(Disp3), .Disp4(Disp4),
        .out_data(outData[0]), .out_valid(outValid[0]), .out_ready(outReady),
        .busy(busy[0]), .done(done[0])
    );

    line_sender #(.SKIP_BLANK(1'b1)) dut1 (
        .clk(clk), .Reset(Reset), .send(send),
        .Disp1(Disp1), .Disp2(Disp2), .Disp3(Disp3), .Disp4(Disp4),
        .out_data(outData[1]), .out_valid(outValid[1]), .out_ready(outReady),
        .busy(busy[1]), .done(done[1])
    );

    line_sender #(.SKIP_BLANK(1'b1), .SEND_TERM(1'b0)) dut2 (
        .clk(clk), .Reset(Reset), .send(send),
        .Disp1(Disp1), .Disp2(Disp2), .Disp3(Disp3), .Disp4(Disp4),
        .out_data(outData[2]), .out_valid(outValid[2]), .out_ready(outReady),
        .busy(busy[2]), .done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input int k, input logic [7:0] b);
        case (k)
            0:       expQ0.push_back(b);
            1:       expQ1.push_back(b);
            default: expQ2.push_back(b);
        endcase
    endtask

    task automatic pushLine(input int k, input logic [39:0] bytes, input int n);
        for (int i = 0; i < n; i++) pushExp(k, bytes[39 - 8*i -: 8]);
    endtask

    function automatic int queueSize(input int k);
        case (k)
            0:       return expQ0.size();
            1:       return expQ1.size();
            default: return expQ2.size();
        endcase
    endfunction

    task automatic popExp(input int k, output logic [7:0] b, output bit ok);
        ok = (queueSize(k) != 0);
        b  = 8'h00;
        if (ok) begin
            case (k)
                0:       b = expQ0.pop_front();
                1:       b = expQ1.pop_front();
                default: b = expQ2.pop_front();
            endcase
        end
    endtask

    // Monitor: every handshake pops one expected byte; stalled bytes must hold.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [7:0] b;
            bit         ok;
            if (stallPrev[k]) begin
                checkOutput($sformatf("hold_valid%0d", k), int'(outValid[k]), 1);
                checkOutput($sformatf("hold_data%0d", k), int'(outData[k]), int'(stallData[k]));
            end
            if (outValid[k] && outReady) begin
                popExp(k, b, ok);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_byte%0d: got %0h, expected none", k, outData[k]);
                end else begin
                    checkOutput($sformatf("byte%0d", k), int'(outData[k]), int'(b));
                end
            end
            stallPrev[k] = outValid[k] && !outReady;
            stallData[k] = outData[k];
            if (done[k]) begin
                doneCnt[k]++;
                doneCyc[k] = cyc;
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] d1, input logic [3:0] d2,
                                 input logic [3:0] d3, input logic [3:0] d4);
        @(posedge clk); #1;
        Disp1 = d1; Disp2 = d2; Disp3 = d3; Disp4 = d4;
        send = 1'b1;
        sendCyc = cyc;
        @(posedge clk); #1;
        send = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_timeout"}, int'(n < 50), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic endVector(input string name, input int d0, input int d1, input int d2,
                             input int r0, input int r1, input int r2);
        int expDone[3];
        int expRel[3];
        expDone = '{d0, d1, d2};
        expRel  = '{r0, r1, r2};
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s_done_count%0d", name, k), doneCnt[k], expDone[k]);
            if (expDone[k] > 0)
                checkOutput($sformatf("%s_done_latency%0d", name, k), doneCyc[k] - sendCyc, expRel[k]);
            checkOutput($sformatf("%s_missing%0d", name, k), queueSize(k), 0);
            doneCnt[k] = 0;
            doneCyc[k] = -1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            doneCnt[k] = 0; doneCyc[k] = -1; stallPrev[k] = 1'b0; stallData[k] = 8'h00;
        end
        Reset = 1'b1; send = 1'b1; outReady = 1'b1;
        Disp1 = 4'h1; Disp2 = 4'h2; Disp3 = 4'h3; Disp4 = 4'h4;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset_valid%0d", k), int'(outValid[k]), 0);
            checkOutput($sformatf("reset_busy%0d", k), int'(busy[k]), 0);
            checkOutput($sformatf("reset_done%0d", k), int'(done[k]), 0);
            checkOutput($sformatf("reset_data%0d", k), int'(outData[k]), 0);
        end
        Reset = 1'b0; send = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) checkOutput($sformatf("post_reset_busy%0d", k), int'(busy[k]), 0);

        // Plain line; digits change right after capture and must not leak in.
        pushLine(0, 40'h31_32_33_34_0D, 5);
        pushLine(1, 40'h31_32_33_34_0D, 5);
        pushLine(2, 40'h31_32_33_34_00, 4);
        applyStimulus(4'h1, 4'h2, 4'h3, 4'h4);
        Disp1 = 4'h9; Disp2 = 4'h9; Disp3 = 4'h9; Disp4 = 4'h9;
        waitIdle("plain");
        endVector("plain", 1, 1, 1, 6, 6, 5);

        // Blank and invalid codes, plus a send while every variant is busy.
        pushLine(0, 40'h30_20_3F_39_0D, 5);
        pushLine(1, 40'h30_3F_39_0D_00, 4);
        pushLine(2, 40'h30_3F_39_00_00, 3);
        applyStimulus(4'h0, 4'hF, 4'hA, 4'h9);
        repeat (3) begin @(posedge clk); #1; end
        send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        waitIdle("mixed");
        endVector("mixed", 1, 1, 1, 6, 5, 4);

        // Consumer stalls for three cycles on the second byte.
        pushLine(0, 40'h31_32_33_34_0D, 5);
        pushLine(1, 40'h31_32_33_34_0D, 5);
        pushLine(2, 40'h31_32_33_34_00, 4);
        applyStimulus(4'h1, 4'h2, 4'h3, 4'h4);
        @(posedge clk); #1;
        outReady = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        outReady = 1'b1;
        waitIdle("stall");
        endVector("stall", 1, 1, 1, 9, 9, 8);

        // All blank: spaces, terminator only, or nothing at all.
        pushLine(0, 40'h20_20_20_20_0D, 5);
        pushLine(1, 40'h0D_00_00_00_00, 1);
        applyStimulus(4'hF, 4'hF, 4'hF, 4'hF);
        waitIdle("blank");
        endVector("blank", 1, 1, 1, 6, 2, 1);

        // Ignored busy send, then reset while the third byte is on the port.
        pushLine(0, 40'h31_32_33_00_00, 3);
        pushLine(1, 40'h31_32_33_00_00, 3);
        pushLine(2, 40'h31_32_33_00_00, 3);
        applyStimulus(4'h1, 4'h2, 4'h3, 4'h4);
        @(posedge clk); #1;
        send = 1'b1;
        @(posedge clk); #1;
        send = 1'b0;
        Reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("abort_valid%0d", k), int'(outValid[k]), 0);
            checkOutput($sformatf("abort_busy%0d", k), int'(busy[k]), 0);
        end
        Reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        endVector("abort", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_sender.md
LINE_SENDER -- requirements
Module: line_sender

Interface
REQ-001 The block SHALL have parameter TERM_CHAR, default 8'h0D, giving the terminator byte sent after the digits.
REQ-002 The block SHALL have parameter SEND_TERM, default 1, which enables the terminator byte when 1.
REQ-003 The block SHALL have parameter SKIP_BLANK, default 0; when 1, positions holding the blank code are not transmitted.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 send  input  1  one-cycle request to transmit the current four-digit line.
REQ-007 Disp1..Disp4  input  4 each  BCD digit per position; Disp1 is leftmost and is sent first.
REQ-008 out_data  output  8  ASCII byte presented to the consumer.
REQ-009 out_valid  output  1  out_data holds a byte awaiting acceptance.
REQ-010 out_ready  input  1  consumer accepts out_data on a cycle where out_valid and out_ready are both 1.
REQ-011 busy  output  1  high from capture until done.
REQ-012 done  output  1  one-cycle pulse when the line, including any terminator, has been fully accepted.

Function
REQ-013 The code mapping SHALL be: 0-9 -> 8'h30-8'h39; 4'hF (blank) -> 8'h20; 4'hA-4'hE -> 8'h3F ('?').
REQ-014 The FSM states SHALL be IDLE, SEND, TERM and FIN.
REQ-015 In IDLE with send=1, the block SHALL capture Disp1..Disp4 into an internal line register at that edge and go to SEND.
REQ-016 Later changes on Disp1..Disp4 SHALL NOT affect the line in flight.
REQ-017 out_valid SHALL rise the cycle after capture, with out_data equal to the first position to be sent.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-019 On acceptance, the block SHALL present the next position the following cycle; there are no bubbles between bytes when out_ready stays 1.
REQ-020 With SKIP_BLANK=1, blank positions SHALL be skipped with no idle cycle; the index advances to the next non-blank position.
REQ-021 After the last position is accepted: with SEND_TERM=1 the block SHALL go to TERM and present TERM_CHAR; otherwise it SHALL go to FIN.
REQ-022 When TERM_CHAR is accepted, the block SHALL go to FIN.
REQ-023 In FIN, done=1 and out_valid=0 for exactly one cycle, then the block SHALL return to IDLE.
REQ-024 If no position qualifies (all blank with SKIP_BLANK=1), the block SHALL go directly to TERM, or to FIN when SEND_TERM=0.
REQ-025 A send while busy=1, including in FIN, SHALL be ignored and not queued.
REQ-026 busy SHALL be 1 in SEND, TERM and FIN, and 0 in IDLE.
REQ-027 out_valid SHALL be 1 only in SEND and TERM.
REQ-028 Latency with out_ready tied 1: send at cycle 0, bytes at cycles 1-4, terminator at cycle 5, done at cycle 6.

Reset
REQ-029 Reset=1 SHALL force IDLE, out_valid=0, busy=0, done=0, out_data=8'h00, position index 0 and line register all 4'hF.
REQ-030 Reset SHALL take priority over send and over acceptance on the same edge.
REQ-031 A reset mid-line SHALL abandon the transfer with no done pulse.

Structure
REQ-032 A shared package SHALL hold the state enum, the BLANK_CODE (4'hF) and QMARK (8'h3F) constants, and the default terminator.
REQ-033 The mapping SHALL be a combinational sub-module named bcd_to_ascii (4-bit in, 8-bit out), instantiated once on the selected position.
REQ-034 The skip-ahead logic SHALL be a combinational next-qualifying-index search over the 4 positions.

Verification
REQ-035 Disp=1,2,3,4, send, out_ready=1 -> bytes 31,32,33,34,0D on consecutive cycles, then one done pulse.
REQ-036 Disp=0,F,A,9, SKIP_BLANK=0 -> bytes 30,20,3F,39,0D.
REQ-037 Same line, SKIP_BLANK=1 -> bytes 30,3F,39,0D.
REQ-038 Backpressure: out_ready low 3 cycles on byte 2 -> out_data holds 32 stably; no byte lost or duplicated.
REQ-039 All F, SKIP_BLANK=1, SEND_TERM=0 -> no out_valid at all; done asserts 1 cycle after send.
REQ-040 Reset during byte 3, plus send while busy -> out_valid low on the next cycle, no done, and the ignored send produces no second line.
